// File: rtl/uriscv_tcm_ext_pkg.sv
// Shared types for the TCM external-port arbiter: FSM states, latched command, range helper.
package uriscv_tcm_ext_pkg;

   localparam int NUM_REQ = 2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

   typedef struct packed {
      logic [3:0]  wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        id;
   } cmd_t;

   // True when no address bit at or above the decoded width is set.
   function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned aw);
      logic [31:0] hi;
      hi = addr >> aw;
      return (hi == 32'd0);
   endfunction

   function automatic logic [NUM_REQ-1:0] id_onehot(input logic id);
      return id ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/uriscv_rr_arb2.sv
// Two-way round-robin arbiter; the priority pointer moves to the other requester on every grant.
module uriscv_rr_arb2 #(
   parameter logic RR_INIT = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic ptr_r;

   // Grant decode: a lone requester wins outright, a tie goes to the pointer.
   always_comb begin
      gnt = 2'b00;
      if (!en) begin
         gnt = 2'b00;
      end else if (req == 2'b11) begin
         gnt = ptr_r ? 2'b10 : 2'b01;
      end else begin
         gnt = req;
      end
   end

   // Pointer update, only when a grant is actually issued.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_r <= RR_INIT;
      end else if (gnt[0]) begin
         ptr_r <= 1'b1;
      end else if (gnt[1]) begin
         ptr_r <= 1'b0;
      end else begin
         ptr_r <= ptr_r;
      end
   end

endmodule

// File: rtl/uriscv_tcm_ext_arb.sv
// Arbitrates debug loader (0) and DMA (1) onto the TCM external port and runs its
// request / accept / read-data sequence, returning one response pulse per command.
module uriscv_tcm_ext_arb #(
   parameter int unsigned TCM_ADDR_W = 16,
   parameter int unsigned RR_INIT    = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid_i,
   output logic        req0_ready_o,
   input  logic [3:0]  req0_wr_i,
   input  logic [31:0] req0_addr_i,
   input  logic [31:0] req0_wdata_i,
   output logic        resp0_valid_o,
   output logic [31:0] resp0_rdata_o,
   output logic        resp0_err_o,
   input  logic        req1_valid_i,
   output logic        req1_ready_o,
   input  logic [3:0]  req1_wr_i,
   input  logic [31:0] req1_addr_i,
   input  logic [31:0] req1_wdata_i,
   output logic        resp1_valid_o,
   output logic [31:0] resp1_rdata_o,
   output logic        resp1_err_o,
   output logic        ext_rd_o,
   output logic [3:0]  ext_wr_o,
   output logic [31:0] ext_addr_o,
   output logic [31:0] ext_write_data_o,
   input  logic [31:0] ext_read_data_i,
   input  logic        ext_accept_i,
   output logic        busy_o
);

   import uriscv_tcm_ext_pkg::*;

   state_e               state_r;
   cmd_t                 cmd_r;
   cmd_t                 cmd_s;
   logic                 err_r;
   logic [NUM_REQ-1:0]   gnt_s;
   logic                 arb_en_s;
   logic                 grant_s;
   logic                 rd_ok_s;
   logic [NUM_REQ-1:0]   resp_valid_r;
   logic                 ext_rd_r;
   logic [3:0]           ext_wr_r;
   logic [31:0]          ext_addr_r;
   logic [31:0]          ext_wdata_r;

   // Grants are only offered in IDLE and never while reset is being applied.
   assign arb_en_s = rst_n & (state_r == ST_IDLE);
   assign grant_s  = |gnt_s;

   uriscv_rr_arb2 #(
      .RR_INIT (1'(RR_INIT))
   ) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (arb_en_s),
      .req   ({req1_valid_i, req0_valid_i}),
      .gnt   (gnt_s)
   );

   // Select the command of whichever requester the arbiter granted.
   always_comb begin
      cmd_s = '0;
      if (gnt_s[1]) begin
         cmd_s.wr    = req1_wr_i;
         cmd_s.addr  = req1_addr_i;
         cmd_s.wdata = req1_wdata_i;
         cmd_s.id    = 1'b1;
      end else begin
         cmd_s.wr    = req0_wr_i;
         cmd_s.addr  = req0_addr_i;
         cmd_s.wdata = req0_wdata_i;
         cmd_s.id    = 1'b0;
      end
   end

   // Access sequencer; ext_* and response strobes are loaded one state ahead so they are registered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         cmd_r        <= '0;
         err_r        <= 1'b0;
         resp_valid_r <= 2'b00;
         ext_rd_r     <= 1'b0;
         ext_wr_r     <= 4'h0;
         ext_addr_r   <= 32'h0;
         ext_wdata_r  <= 32'h0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               resp_valid_r <= 2'b00;
               ext_rd_r     <= 1'b0;
               ext_wr_r     <= 4'h0;
               ext_addr_r   <= 32'h0;
               ext_wdata_r  <= 32'h0;
               if (grant_s) begin
                  cmd_r <= cmd_s;
                  if (!addr_in_range(cmd_s.addr, TCM_ADDR_W)) begin
                     err_r        <= 1'b1;
                     resp_valid_r <= id_onehot(cmd_s.id);
                     state_r      <= ST_RESP;
                  end else begin
                     err_r       <= 1'b0;
                     ext_rd_r    <= (cmd_s.wr == 4'h0);
                     ext_wr_r    <= cmd_s.wr;
                     ext_addr_r  <= cmd_s.addr;
                     ext_wdata_r <= cmd_s.wdata;
                     state_r     <= ST_ISSUE;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_ISSUE: begin
               // Drop the strobes but keep the address: the TCM muxes it in the accept slot.
               ext_rd_r    <= 1'b0;
               ext_wr_r    <= 4'h0;
               ext_addr_r  <= cmd_r.addr;
               ext_wdata_r <= cmd_r.wdata;
               state_r     <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (!ext_accept_i) begin
                  err_r <= 1'b1;
               end else begin
                  err_r <= err_r;
               end
               ext_addr_r   <= 32'h0;
               ext_wdata_r  <= 32'h0;
               resp_valid_r <= id_onehot(cmd_r.id);
               state_r      <= ST_RESP;
            end
            ST_RESP: begin
               resp_valid_r <= 2'b00;
               state_r      <= ST_IDLE;
            end
            default: begin
               resp_valid_r <= 2'b00;
               ext_rd_r     <= 1'b0;
               ext_wr_r     <= 4'h0;
               ext_addr_r   <= 32'h0;
               ext_wdata_r  <= 32'h0;
               state_r      <= ST_IDLE;
            end
         endcase
      end
   end

   // TCM read data is registered by the TCM itself and is only valid during RESP.
   assign rd_ok_s = (state_r == ST_RESP) & ~err_r & (cmd_r.wr == 4'h0);

   assign req0_ready_o     = gnt_s[0];
   assign req1_ready_o     = gnt_s[1];
   assign resp0_valid_o    = resp_valid_r[0];
   assign resp1_valid_o    = resp_valid_r[1];
   assign resp0_rdata_o    = (resp_valid_r[0] & rd_ok_s) ? ext_read_data_i : 32'h0;
   assign resp1_rdata_o    = (resp_valid_r[1] & rd_ok_s) ? ext_read_data_i : 32'h0;
   assign resp0_err_o      = resp_valid_r[0] & err_r;
   assign resp1_err_o      = resp_valid_r[1] & err_r;
   assign ext_rd_o         = ext_rd_r;
   assign ext_wr_o         = ext_wr_r;
   assign ext_addr_o       = ext_addr_r;
   assign ext_write_data_o = ext_wdata_r;
   assign busy_o           = (state_r != ST_IDLE);

endmodule

// File: tb/tb_uriscv_tcm_ext_arb.sv
// Randomized and directed bench for uriscv_tcm_ext_arb against a transaction-level model.
module tb_uriscv_tcm_ext_arb;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        b_valid [2];
   logic [3:0]  b_wr [2];
   logic [31:0] b_addr [2];
   logic [31:0] b_wdata [2];
   logic        b_noacc = 1'b0;
   logic        req0_ready_o, req1_ready_o, resp0_valid_o, resp1_valid_o, resp0_err_o, resp1_err_o;
   logic [31:0] resp0_rdata_o, resp1_rdata_o;
   logic        ext_rd_o, ext_accept_i, busy_o;
   logic [3:0]  ext_wr_o;
   logic [31:0] ext_addr_o, ext_write_data_o;
   logic [31:0] ext_read_data_i = 32'h0;

   int checks = 0;
   int passes = 0;
   int rr = 0;
   logic [31:0] ref_mem [0:16383];

   uriscv_tcm_ext_arb dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid_i(b_valid[0]), .req0_ready_o(req0_ready_o), .req0_wr_i(b_wr[0]),
      .req0_addr_i(b_addr[0]), .req0_wdata_i(b_wdata[0]),
      .resp0_valid_o(resp0_valid_o), .resp0_rdata_o(resp0_rdata_o), .resp0_err_o(resp0_err_o),
      .req1_valid_i(b_valid[1]), .req1_ready_o(req1_ready_o), .req1_wr_i(b_wr[1]),
      .req1_addr_i(b_addr[1]), .req1_wdata_i(b_wdata[1]),
      .resp1_valid_o(resp1_valid_o), .resp1_rdata_o(resp1_rdata_o), .resp1_err_o(resp1_err_o),
      .ext_rd_o(ext_rd_o), .ext_wr_o(ext_wr_o), .ext_addr_o(ext_addr_o),
      .ext_write_data_o(ext_write_data_o), .ext_read_data_i(ext_read_data_i),
      .ext_accept_i(ext_accept_i), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int i);
      if (i == 4) return 32'hDEADBEEF;
      if (i == 8) return 32'h11223344;
      return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   // TCM behavioural model: accept slot follows a request, read data registered after accept.
   logic       tcm_pend = 1'b0;
   logic [3:0] tcm_wr_q = 4'h0;
   bit         tcm_loaded = 1'b0;
   logic [31:0] tcm_mem [0:16383];
   assign ext_accept_i = tcm_pend & ~b_noacc;

   always @(posedge clk) begin
      if (!tcm_loaded) begin
         for (int i = 0; i < 16384; i++) tcm_mem[i] <= init_word(i);
         tcm_loaded <= 1'b1;
      end else begin
         tcm_pend <= ext_rd_o | (|ext_wr_o);
         tcm_wr_q <= ext_wr_o;
         if (ext_accept_i) begin
            for (int b = 0; b < 4; b++)
               if (tcm_wr_q[b]) tcm_mem[ext_addr_o[15:2]][8*b +: 8] <= ext_write_data_o[8*b +: 8];
            ext_read_data_i <= tcm_mem[ext_addr_o[15:2]];
         end else begin
            ext_read_data_i <= $urandom;
         end
      end
   end

   // One or two commands presented together; model predicts grants, ext phases and responses.
   task automatic serve(input bit v0, input bit v1, input logic [3:0] w0, input logic [3:0] w1,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input bit noacc, input bit may_drop, input string tag);
      bit pend [2];
      bit active, oor, e_err;
      int g, gid, ph, rph, budget, o;
      logic [3:0] gw;
      logic [31:0] ga, gd, e_rd, e_addr, e_wd, idx;
      logic [8:0] obs, expv;
      logic [65:0] obs_r, exp_r;
      pend[0] = v0; pend[1] = v1; active = 1'b0; budget = 0; ph = 0; rph = 0; gid = 0;
      gw = 4'h0; ga = 32'h0; gd = 32'h0; e_rd = 32'h0; e_err = 1'b0; oor = 1'b0;
      b_wr[0] = w0; b_addr[0] = a0; b_wdata[0] = d0;
      b_wr[1] = w1; b_addr[1] = a1; b_wdata[1] = d1;
      b_noacc = noacc;
      while ((pend[0] || pend[1] || active) && budget < 60) begin
         b_valid[0] = pend[0]; b_valid[1] = pend[1];
         #1;
         expv = 9'h0; e_addr = 32'h0; e_wd = 32'h0; g = -1;
         if (!active) begin
            if (pend[0] && pend[1]) g = rr;
            else if (pend[0]) g = 0;
            else if (pend[1]) g = 1;
            if (g == 0) expv[8] = 1'b1;
            if (g == 1) expv[7] = 1'b1;
         end else begin
            expv[4] = 1'b1;
            if (ph == rph) begin
               if (gid == 0) expv[6] = 1'b1; else expv[5] = 1'b1;
            end else if (ph == 1) begin
               expv[3] = (gw == 4'h0); expv[2:0] = 3'h0; expv[3:0] = {(gw == 4'h0), gw[3:1]};
            end
            if (!oor && (ph == 1 || ph == 2)) begin e_addr = ga; e_wd = gd; end
         end
         obs = {req0_ready_o, req1_ready_o, resp0_valid_o, resp1_valid_o, busy_o, ext_rd_o, ext_wr_o[3:1]};
         checks++;
         if (obs !== expv || (active && ph == 1 && !oor && ext_wr_o[0] !== gw[0]) ||
             (!(active && ph == 1 && !oor) && ext_wr_o[0] !== 1'b0))
            $display("FAIL %s status ph=%0d: got rdy/rsp/busy/rd/wr=%b wr0=%b want %b", tag, ph, obs, ext_wr_o[0], expv);
         else passes++;
         if (!(active && ph == rph)) begin
            checks++;
            if ({ext_addr_o, ext_write_data_o} !== {e_addr, e_wd})
               $display("FAIL %s ext_addr/wdata ph=%0d: got %h/%h want %h/%h", tag, ph, ext_addr_o, ext_write_data_o, e_addr, e_wd);
            else passes++;
         end else begin
            obs_r = {resp0_rdata_o, resp0_err_o, resp1_rdata_o, resp1_err_o};
            exp_r = (gid == 0) ? {e_rd, e_err, 33'h0} : {33'h0, e_rd, e_err};
            checks++;
            if (obs_r !== exp_r) $display("FAIL %s resp data/err: got %h want %h", tag, obs_r, exp_r);
            else passes++;
            active = 1'b0;
         end
         if (g >= 0) begin
            active = 1'b1; gid = g; ph = 0; pend[g] = 1'b0; rr = 1 - g;
            gw = b_wr[g]; ga = b_addr[g]; gd = b_wdata[g];
            oor = (ga[31:16] != 16'h0);
            rph = oor ? 1 : 3;
            e_err = oor || noacc;
            idx = {18'h0, ga[15:2]};
            e_rd = (!e_err && gw == 4'h0) ? ref_mem[idx] : 32'h0;
            if (!e_err && gw != 4'h0)
               for (int b = 0; b < 4; b++) if (gw[b]) ref_mem[idx][8*b +: 8] = gd[8*b +: 8];
         end
         o = 1 - gid;
         if (may_drop && active && pend[o] && $urandom_range(0, 7) == 0) pend[o] = 1'b0;
         @(negedge clk);
         if (active) ph++;
         budget++;
      end
      if (budget >= 60) begin
         checks++;
         $display("FAIL %s timeout: got no completion within %0d cycles want completion", tag, budget);
      end
      b_valid[0] = 1'b0; b_valid[1] = 1'b0; b_noacc = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      logic [169:0] obs;
      obs = {req0_ready_o, req1_ready_o, resp0_valid_o, resp1_valid_o, resp0_rdata_o, resp1_rdata_o,
             resp0_err_o, resp1_err_o, ext_rd_o, ext_wr_o, ext_addr_o, ext_write_data_o, busy_o};
      checks++;
      if (obs !== 170'h0) $display("FAIL %s outputs: got %h want 0", tag, obs);
      else passes++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; b_valid[0] = 1'b1; b_valid[1] = 1'b1;
      b_wr[0] = 4'h0; b_wr[1] = 4'h0; b_addr[0] = 32'h0; b_addr[1] = 32'h0;
      b_wdata[0] = 32'h0; b_wdata[1] = 32'h0;
      repeat (3) @(negedge clk);
      check_all_zero("reset_valid_high");
      b_valid[0] = 1'b0; b_valid[1] = 1'b0; #1;
      check_all_zero("reset_idle");
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      check_all_zero("after_reset");
      rr = 0;
   endtask

   task automatic test_contention();
      serve(1'b1, 1'b1, 4'h0, 4'h0, 32'h10, 32'h20, 32'h0, 32'h0, 1'b0, 1'b0, "contend_a");
      serve(1'b1, 1'b1, 4'h0, 4'h0, 32'h24, 32'h14, 32'h0, 32'h0, 1'b0, 1'b0, "contend_b");
   endtask

   task automatic test_single_read();
      serve(1'b1, 1'b0, 4'h0, 4'h0, 32'h10, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, "single_read");
   endtask

   task automatic test_byte_write();
      serve(1'b0, 1'b1, 4'h0, 4'b0100, 32'h0, 32'h20, 32'h0, 32'h00AA0000, 1'b0, 1'b0, "byte_write");
      checks++;
      if (ref_mem[8] !== 32'h11AA3344) $display("FAIL byte_merge model: got %h want 11aa3344", ref_mem[8]);
      else passes++;
      serve(1'b0, 1'b1, 4'h0, 4'h0, 32'h0, 32'h20, 32'h0, 32'h0, 1'b0, 1'b0, "byte_readback");
   endtask

   task automatic test_range_error();
      serve(1'b1, 1'b0, 4'h0, 4'h0, 32'h0001_0000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, "range_rd");
      serve(1'b0, 1'b1, 4'h0, 4'hF, 32'h0, 32'h8000_0004, 32'h0, 32'h12345678, 1'b0, 1'b0, "range_wr");
   endtask

   task automatic test_protocol_fault();
      serve(1'b1, 1'b0, 4'hF, 4'h0, 32'h30, 32'h0, 32'hCAFEF00D, 32'h0, 1'b1, 1'b0, "fault_wr");
      serve(1'b1, 1'b0, 4'h0, 4'h0, 32'h30, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, "fault_next");
   endtask

   task automatic test_reset_in_access();
      b_wr[0] = 4'h0; b_addr[0] = 32'h40; b_valid[0] = 1'b1; b_valid[1] = 1'b0; #1;
      checks++;
      if (req0_ready_o !== 1'b1) $display("FAIL rst_access grant: got %b want 1", req0_ready_o);
      else passes++;
      @(negedge clk); b_valid[0] = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy_o, ext_rd_o, ext_addr_o} !== {1'b1, 1'b0, 32'h40})
         $display("FAIL rst_access in_access: got %b %b %h want 1 0 00000040", busy_o, ext_rd_o, ext_addr_o);
      else passes++;
      rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      check_all_zero("rst_access_after");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_all_zero("rst_access_quiet");
      end
      rr = 0;
      serve(1'b1, 1'b1, 4'h0, 4'h0, 32'h44, 32'h48, 32'h0, 32'h0, 1'b0, 1'b0, "rst_access_rr");
   endtask

   task automatic test_back_to_back();
      logic [3:0] w [2];
      logic [31:0] a [2];
      int r;
      for (int n = 0; n < 60; n++) begin
         r = $urandom_range(1, 3);
         for (int k = 0; k < 2; k++) begin
            w[k] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            if ($urandom_range(0, 9) == 0) a[k] = 32'h0001_0000 << $urandom_range(0, 15);
            else a[k] = 32'($urandom_range(0, 63)) << 2;
         end
         serve(r[0], r[1], w[0], w[1], a[0], a[1], $urandom, $urandom,
               ($urandom_range(0, 9) == 0), 1'b1, "random");
      end
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) ref_mem[i] = init_word(i);
      test_reset();
      test_contention();
      test_single_read();
      test_byte_write();
      test_range_error();
      test_protocol_fault();
      test_reset_in_access();
      test_back_to_back();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
